// File: rtl/selector_pkg.sv
// Shared types and default sizing for the selector demux.
package selector_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 8;

    // Input-side packet routing state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2
    } state_e;

endpackage

// File: rtl/demux_out_stage.sv
// One output channel: a single-entry register slice plus a delivered-packet counter.
module demux_out_stage
    import selector_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic             space_c_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pop_c;

    // Slice can take a new beat when empty or when its current beat leaves this cycle
    assign pop_c     = valid_q && ready_i;
    assign space_c_o = !valid_q || ready_i;

    // Next-state for the slice and counter; load wins over pop so both can happen in one cycle
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (pop_c) begin
            valid_d = 1'b0;
        end
        if (pop_c && last_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Slice and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= WIDTH'(0);
            last_q  <= 1'b0;
            cnt_q   <= CNT_W'(0);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign last_o    = last_q;
    assign pkt_cnt_o = cnt_q;

endmodule

// File: rtl/selector_demux.sv
// Packet demux: routes whole packets to one of two channels, selected on the first beat.
module selector_demux
    import selector_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic             busy
);

    state_e state_q, state_d;
    logic   busy_q;
    logic   tgt1_c;
    logic   space0_c, space1_c;
    logic   in_acc_c;
    logic   load0_c, load1_c;

    // Target channel: live select only at a packet start, locked afterwards
    assign tgt1_c   = (state_q == ROUTE1) || ((state_q == IDLE) && in_sel);
    assign in_ready = tgt1_c ? space1_c : space0_c;
    assign in_acc_c = in_valid && in_ready;
    assign load0_c  = in_acc_c && !tgt1_c;
    assign load1_c  = in_acc_c && tgt1_c;

    // Next-state: open a route on a multi-beat start, close it on the last beat
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_acc_c && !in_last) begin
                    state_d = in_sel ? ROUTE1 : ROUTE0;
                end
            end
            ROUTE0, ROUTE1: begin
                if (in_acc_c && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; busy tracks the registered state so it needs no output decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign busy = busy_q;

    demux_out_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_stage0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load0_c),
        .data_i    (in_data),
        .last_i    (in_last),
        .ready_i   (out0_ready),
        .valid_o   (out0_valid),
        .data_o    (out0_data),
        .last_o    (out0_last),
        .pkt_cnt_o (pkt_cnt0),
        .space_c_o (space0_c)
    );

    demux_out_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load1_c),
        .data_i    (in_data),
        .last_i    (in_last),
        .ready_i   (out1_ready),
        .valid_o   (out1_valid),
        .data_o    (out1_data),
        .last_o    (out1_last),
        .pkt_cnt_o (pkt_cnt1),
        .space_c_o (space1_c)
    );

endmodule

// File: doc/selector_demux.md
SELECTOR_DEMUX -- requirements
Module: selector_demux

Interface
REQ-001 Parameter: WIDTH, 8, data width of every beat.
REQ-002 Parameter: CNT_W, 8, width of per-channel packet counters.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  block accepts the current beat.
REQ-007 in_data  input  WIDTH  beat payload.
REQ-008 in_sel  input  1  destination channel; sampled only on a packet's first beat.
REQ-009 in_last  input  1  marks final beat of a packet.
REQ-010 out0_valid, out1_valid  output  1 each  channel beat present.
REQ-011 out0_ready, out1_ready  input  1 each  downstream accepts beat.
REQ-012 out0_data, out1_data  output  WIDTH each  channel payload.
REQ-013 out0_last, out1_last  output  1 each  channel end-of-packet.
REQ-014 pkt_cnt0, pkt_cnt1  output  CNT_W each  packets delivered per channel.
REQ-015 busy  output  1  high while a packet is in progress on the input side.

Function
REQ-016 Input accept SHALL be in_valid && in_ready; output accept SHALL be outX_valid && outX_ready.
REQ-017 FSM states SHALL be IDLE, ROUTE0, ROUTE1; target channel SHALL be in_sel in IDLE, 0 in ROUTE0, and 1 in ROUTE1.
REQ-018 IDLE, accepted beat, in_last=0 -> ROUTE<in_sel>; in_last=1 -> stay IDLE (single-beat packet).
REQ-019 ROUTEx, accepted beat with in_last=1 -> IDLE; otherwise stay; in_sel SHALL be ignored.
REQ-020 busy SHALL be 1 exactly in ROUTE0/ROUTE1.
REQ-021 Each channel SHALL have one output register slice (valid, data, last).
REQ-022 in_ready SHALL be combinational: !target_valid || target_ready; no combinational path from in_valid to in_ready.
REQ-023 Latency SHALL be 1 cycle: a beat accepted at edge N appears on outX at edge N and stays until accepted.
REQ-024 Throughput SHALL be one beat/cycle when target ready is held high.
REQ-025 Non-target channel SHALL drain independently; loading one channel while the other is accepted in the same cycle SHALL both occur.
REQ-026 Output slice SHALL hold data/last stable while valid && !ready.
REQ-027 pkt_cntX SHALL increment by 1 on an outX accept with outX_last=1 and SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 A beat SHALL never be duplicated, dropped, or delivered to the non-target channel.

Reset
REQ-029 rst_n low SHALL force, asynchronously, state=IDLE, out0_valid=out1_valid=0, out*_data=0, out*_last=0, pkt_cnt0=pkt_cnt1=0, busy=0.
REQ-030 Reset mid-packet SHALL discard held beats and the partial packet; the first accepted beat after release SHALL be treated as a packet start.
REQ-031 in_ready SHALL be 1 in the first cycle after reset release (both slices empty).

Structure
REQ-032 Shared package selector_pkg SHALL hold the state enum (IDLE/ROUTE0/ROUTE1) and default WIDTH/CNT_W constants.
REQ-033 Sub-module demux_out_stage (one register slice plus its packet counter) SHALL be instantiated twice; the FSM and routing SHALL stay in the top.

Verification
REQ-034 1-beat packet: sel=1, data=8'hA5, last=1, out1_ready=1 -> out1 shows A5/last next edge, pkt_cnt1=1, out0_valid stays 0.
REQ-035 Sel lock: 3-beat packet, sel=0 then sel toggled to 1 on beats 2-3 -> all three beats (11,22,33) go to out0 only, state returns to IDLE.
REQ-036 Backpressure: out0_ready=0 with out0 slice full -> in_ready=0 for target 0, data held stable; release -> beat accepted, no loss.
REQ-037 Parallel: out1 holding a beat with out1_ready=0 while a packet streams to out0 -> out0 runs at 1 beat/cycle, out1 data unchanged.
REQ-038 Wrap: 256 single-beat packets to channel 0 with CNT_W=8 -> pkt_cnt0 returns to 0.
REQ-039 Reset mid-packet in ROUTE1 -> all outputs 0 immediately, busy=0; the next beat with sel=0 routes to out0.
